// File: rtl/adv7393_frame_reader_pkg.sv
// Shared types and constants for the ADV7393 frame reader: AXI field values,
// video timing defaults and the read-FSM state type.
package adv7393_frame_reader_pkg;

  localparam int AXI_DWIDTH     = 64;
  localparam int H_ACTIVE_PAL   = 720;
  localparam int V_ACTIVE_PAL   = 576;
  localparam int H_ACTIVE_NTSC  = 720;
  localparam int V_ACTIVE_NTSC  = 480;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [3:0] AR_CACHE   = 4'b0011;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CREDIT,
    ADDR,
    DATA,
    LINE_END
  } rd_state_t;

  function automatic logic [2:0] clog2_bytes(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/adv7393_frame_reader_if.sv
// AXI4 read channels plus the beat stream towards the pixel-domain FIFO.
interface adv7393_frame_reader_if #(
  parameter int DW = 64
);
  logic [31:0]   m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arlock;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic [3:0]    m_axi_arregion;
  logic [3:0]    m_axi_arqos;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eol;

  modport master (
    output m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
           m_axi_arcache, m_axi_arprot, m_axi_arregion, m_axi_arqos, m_axi_arvalid,
    input  m_axi_arready,
    input  m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    output m_axi_rready,
    output out_data, out_valid, out_sof, out_eol,
    input  out_ready
  );

  modport slave (
    input  m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
           m_axi_arcache, m_axi_arprot, m_axi_arregion, m_axi_arqos, m_axi_arvalid,
    output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid,
    input  m_axi_rready,
    input  out_data, out_valid, out_sof, out_eol,
    output out_ready
  );
endinterface

// File: rtl/adv7393_frame_reader_burst_planner.sv
// Sizes the next burst of a line and holds the AR address/length registers
// stable from issue until the address handshake.
module adv7393_frame_reader_burst_planner #(
  parameter int DW             = 64,
  parameter int BURST_LEN      = 16,
  parameter int BEATS_PER_LINE = 180,
  parameter int BL_W           = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [BL_W-1:0] beats_left,
  input  logic [31:0]     line_addr,
  output logic [8:0]      n,
  output logic            last_burst,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen
);

  logic [31:0] offset;

  always_comb begin
    last_burst = int'(beats_left) <= BURST_LEN;
    n          = last_burst ? 9'(beats_left) : 9'(BURST_LEN);
    offset     = 32'((BEATS_PER_LINE - int'(beats_left)) * (DW / 8));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      araddr <= '0;
      arlen  <= '0;
    end else if (load) begin
      araddr <= line_addr + offset;
      arlen  <= 8'(n - 9'd1);
    end
  end

endmodule

// File: rtl/adv7393_frame_reader.sv
// Fetches one frame of 16-bit pixels per frame_start as single-outstanding
// AXI4 read bursts and forwards the beats with sof/eol markers.
module adv7393_frame_reader
  import adv7393_frame_reader_pkg::*;
#(
  parameter int M_AXI_DWIDTH = AXI_DWIDTH,
  parameter int H_ACTIVE     = H_ACTIVE_PAL,
  parameter int V_ACTIVE     = V_ACTIVE_PAL,
  parameter int BURST_LEN    = 16,
  parameter int FIFO_CNT_W   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  frame_start,
  input  logic [31:0]           base_addr,
  input  logic [31:0]           line_stride,
  input  logic [FIFO_CNT_W-1:0] fifo_free,
  adv7393_frame_reader_if.master bus,
  output logic                  busy,
  output logic                  rresp_err,
  output logic                  frame_overrun
);

  // state       | meaning
  // IDLE        | no frame in progress
  // WAIT_CREDIT | waiting for FIFO room for the next burst
  // ADDR        | AR presented, waiting for arready
  // DATA        | forwarding R beats of the current burst
  // LINE_END    | advance to the next line or finish the frame

  localparam int BPL    = H_ACTIVE * 16 / M_AXI_DWIDTH;
  localparam int BL_W   = $clog2(BPL + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);

  if ((H_ACTIVE * 16) % M_AXI_DWIDTH != 0) begin : g_bad_width
    $error("H_ACTIVE*16 must be a multiple of M_AXI_DWIDTH");
  end

  rd_state_t         state, state_nxt;
  logic [31:0]       line_addr, stride_q;
  logic [LINE_W-1:0] line;
  logic [BL_W-1:0]   beats_left;
  logic [8:0]        burst_cnt, n;
  logic              sof_pend, last_burst, issue, beat_hs, burst_done;

  adv7393_frame_reader_burst_planner #(
    .DW(M_AXI_DWIDTH), .BURST_LEN(BURST_LEN), .BEATS_PER_LINE(BPL), .BL_W(BL_W)
  ) u_planner (
    .clk(clk), .reset(reset), .load(issue), .beats_left(beats_left),
    .line_addr(line_addr), .n(n), .last_burst(last_burst),
    .araddr(bus.m_axi_araddr), .arlen(bus.m_axi_arlen)
  );

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    beat_hs    = 1'b0;
    burst_done = 1'b0;
    case (state)
      IDLE:        if (frame_start && enable) state_nxt = WAIT_CREDIT;
      WAIT_CREDIT: if (32'(fifo_free) >= 32'(n)) begin
        issue     = 1'b1;
        state_nxt = ADDR;
      end
      ADDR:        if (bus.m_axi_arready) state_nxt = DATA;
      DATA: begin
        beat_hs = bus.m_axi_rvalid && bus.out_ready;
        // The local beat count ends the burst, whatever rlast says.
        if (beat_hs && burst_cnt == 9'd1) begin
          burst_done = 1'b1;
          state_nxt  = last_burst ? LINE_END : WAIT_CREDIT;
        end
      end
      LINE_END:    state_nxt = (int'(line) == V_ACTIVE - 1) ? IDLE : WAIT_CREDIT;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      line_addr     <= '0;
      stride_q      <= '0;
      line          <= '0;
      beats_left    <= '0;
      burst_cnt     <= '0;
      sof_pend      <= 1'b0;
      rresp_err     <= 1'b0;
      frame_overrun <= 1'b0;
    end else begin
      state         <= state_nxt;
      frame_overrun <= frame_start && busy;
      case (state)
        IDLE: if (frame_start && enable) begin
          line_addr  <= base_addr;
          stride_q   <= line_stride;
          line       <= '0;
          beats_left <= BL_W'(BPL);
          sof_pend   <= 1'b1;
        end
        WAIT_CREDIT: if (issue) burst_cnt <= n;
        DATA: if (beat_hs) begin
          burst_cnt <= burst_cnt - 9'd1;
          sof_pend  <= 1'b0;
          if (bus.m_axi_rresp != RESP_OKAY || bus.m_axi_rlast != (burst_cnt == 9'd1))
            rresp_err <= 1'b1;
          if (burst_done && !last_burst) beats_left <= beats_left - BL_W'(n);
        end
        LINE_END: begin
          line <= line + 1'b1;
          if (state_nxt != IDLE) begin
            line_addr  <= line_addr + stride_q;
            beats_left <= BL_W'(BPL);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy               = (state != IDLE);
  assign bus.m_axi_arvalid  = (state == ADDR);
  assign bus.m_axi_arsize   = clog2_bytes(M_AXI_DWIDTH);
  assign bus.m_axi_arburst  = BURST_INCR;
  assign bus.m_axi_arcache  = AR_CACHE;
  assign bus.m_axi_arlock   = 1'b0;
  assign bus.m_axi_arprot   = 3'd0;
  assign bus.m_axi_arregion = 4'd0;
  assign bus.m_axi_arqos    = 4'd0;
  assign bus.m_axi_rready   = (state == DATA) && bus.out_ready;
  assign bus.out_valid      = (state == DATA) && bus.m_axi_rvalid;
  assign bus.out_data       = bus.m_axi_rdata;
  assign bus.out_sof        = (state == DATA) && sof_pend;
  assign bus.out_eol        = (state == DATA) && last_burst && (burst_cnt == 9'd1);

endmodule
